img_ram_loader: RTL and testbench
=================================

Name: img_ram_loader

Overview:
- Upstream stage of the image RAM in the VGA image receiver.
- Consumes the byte stream from the UART receiver, detects a frame-start sync byte, and writes the next NumPixels bytes sequentially into the RAM's single shared port.
- When not writing, it passes the VGA display's read address through, so the RAM sees one arbitrated port: rw '1' = read, '0' = write.

Parameters:
- AddressWidth, 14, RAM address width; must match the RAM instance.
- DataWidth, 8, pixel/byte width.
- NumPixels, 16384, bytes per frame; 1 <= NumPixels <= 2**AddressWidth.
- SyncByte, 8'hA5, frame-start marker accepted in IDLE.
- TimeoutCycles, 1000000, maximum clk cycles allowed between bytes while loading.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx_data  input  DataWidth  byte from UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- rd_addr  input  AddressWidth  display read address.
- ram_rw  output  1  to RAM rw; 1 = read, 0 = write; registered.
- ram_addr  output  AddressWidth  to RAM addr; registered.
- ram_data  output  DataWidth  to RAM data_in; registered.
- loading  output  1  high while in LOAD state.
- frame_done  output  1  one-cycle pulse: full frame written.
- frame_err  output  1  one-cycle pulse: load aborted on timeout.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - ram_rw=1, ram_addr=0, ram_data=0.
  - loading=0, frame_done=0, frame_err=0.
  - Pixel counter and timeout counter cleared.
- Read pass-through:
  - Any cycle with no write issued: ram_rw<=1, ram_addr<=rd_addr.
  - Latency rd_addr -> RAM data_out is 2 clk; the display pipeline accounts for this.
  - During LOAD, read cycles between writes still pass rd_addr through; the display shows partial/stale data, which is accepted.
- States:
  - IDLE: rx_valid with rx_data==SyncByte -> LOAD; pixel counter=0, timeout counter=0. All other bytes are ignored and nothing is written.
  - LOAD: each rx_valid byte is accepted. On the next edge: ram_rw<=0, ram_addr<=pixel counter, ram_data<=rx_data. The counter increments; the timeout counter clears.
    - Write occupies exactly one cycle; ram_rw returns to 1 the following cycle unless another byte arrives.
    - Back-to-back rx_valid on consecutive cycles gives consecutive write cycles.
    - SyncByte inside LOAD is ordinary pixel data.
  - Frame completion: the accepted byte is number NumPixels (counter == NumPixels-1 at accept).
    - The final write is issued and frame_done=1 in the same cycle as that write (ram_rw=0).
    - state -> IDLE; no further writes.
  - Timeout: in LOAD, the timeout counter increments on every cycle without rx_valid.
    - When it reaches TimeoutCycles-1 and no rx_valid is present this cycle: frame_err pulses next cycle, state -> IDLE, no write.
    - rx_valid in the expiry cycle: the byte is accepted and the timeout is cancelled.
- loading is 1 exactly while state==LOAD; the registered output changes on the state-change edge.
- Counters:
  - Pixel counter is AddressWidth+1 bits wide, so NumPixels == 2**AddressWidth does not overflow the compare.
  - The address written is the low AddressWidth bits.
  - Timeout counter is sized $clog2(TimeoutCycles)+1.
- Reset mid-LOAD: immediate return to IDLE, ram_rw=1. Bytes already written remain in RAM; there is no done/err pulse.
- frame_done and frame_err are never high together.

Test Plan:
- Params: NumPixels=4, TimeoutCycles=16, AddressWidth=4.
- Bytes 0x11, 0x22 in IDLE -> no write (ram_rw stays 1); ram_addr tracks rd_addr with one-cycle lag.
- rx 0xA5, then 0x01,0x02,0x03,0x04 (gaps of 3 clk) -> writes addr0..3 = 01..04, one cycle each; frame_done pulses with the addr3 write; loading drops; readback via rd_addr returns 01..04 after 2 clk.
- Frame sent with back-to-back rx_valid -> 4 consecutive ram_rw=0 cycles, addresses 0,1,2,3.
- 0xA5, 0x10, then silence -> single write addr0=0x10; frame_err pulses after 16 idle cycles; IDLE; next 0x55 not written.
- 0xA5, 0xA5, 0xB0, 0xC0, 0xD0 -> addr0=0xA5 (sync byte treated as data), frame_done on 0xD0.
- 0xA5, 0x01, assert rst asynchronously mid-cycle -> outputs go to reset values without a clock edge; after release, 0x02 is not written until a new 0xA5.

Source files
------------

// File: rtl/img_ram_loader.sv
// Image RAM write-side loader: waits for a sync byte, writes the next NumPixels
// UART bytes into RAM, and otherwise forwards the display read address.
module img_ram_loader #(
  parameter int                  AddressWidth  = 14,
  parameter int                  DataWidth     = 8,
  parameter int                  NumPixels     = 16384,
  parameter logic [DataWidth-1:0] SyncByte     = 8'hA5,
  parameter int                  TimeoutCycles = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DataWidth-1:0]    rx_data,
  input  logic                    rx_valid,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic                    ram_rw,
  output logic [AddressWidth-1:0] ram_addr,
  output logic [DataWidth-1:0]    ram_data,
  output logic                    loading,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam int TW = $clog2(TimeoutCycles) + 1;
  localparam int PW = AddressWidth + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  // One extra counter bit keeps NumPixels == 2**AddressWidth comparable.
  localparam logic [PW-1:0] LAST_PIX  = PW'(NumPixels - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TimeoutCycles - 1);

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wr, done_d, err_d;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    wr      = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SyncByte) begin
          state_d = S_LOAD;
          pcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          // A byte in the expiry cycle still wins over the timeout.
          wr     = 1'b1;
          pcnt_d = pcnt_q + 1'b1;
          tcnt_d = '0;
          if (pcnt_q == LAST_PIX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tcnt_q == LAST_TICK) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pcnt_q     <= '0;
      tcnt_q     <= '0;
      ram_rw     <= 1'b1;
      ram_addr   <= '0;
      ram_data   <= '0;
      loading    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tcnt_q     <= tcnt_d;
      ram_rw     <= ~wr;
      ram_addr   <= wr ? pcnt_q[AddressWidth-1:0] : rd_addr;
      if (wr) ram_data <= rx_data;
      loading    <= (state_d == S_LOAD);
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_img_ram_loader.sv
// Directed bench for img_ram_loader with a small 2-cycle-latency RAM model.
module tb_img_ram_loader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          loading, frame_done, frame_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout;

  img_ram_loader #(
    .AddressWidth(AW), .DataWidth(DW), .NumPixels(4),
    .SyncByte(8'hA5), .TimeoutCycles(16)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_addr(rd_addr), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_data(ram_data), .loading(loading), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write when rw=0, registered read.
  always @(posedge clk) begin
    if (ram_rw === 1'b0) begin
      mem[ram_addr] <= ram_data;
      wr_cnt <= wr_cnt + 1;
    end
    dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    checks++;
    if (frame_done === 1'b1 && frame_err === 1'b1) begin
      errors++; $display("FAIL done_err_overlap: done=%b err=%b, required not both 1", frame_done, frame_err);
    end
  end

  task automatic send(input logic [DW-1:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ram_rw !== 1'b1) begin errors++; $display("FAIL reset_rw: got %b exp 1", ram_rw); end
    checks++; if (ram_addr !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", ram_addr); end
    checks++; if (ram_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", ram_data); end
    checks++; if ({loading, frame_done, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {loading, frame_done, frame_err}); end
    rst = 1'b0;
  endtask

  task automatic test_idle_ignore;
    int base;
    base = wr_cnt;
    rd_addr = 4'h5;
    send(8'h11);
    checks++; if (ram_rw !== 1'b1) begin errors++; $display("FAIL idle_rw: got %b exp 1", ram_rw); end
    checks++; if (ram_addr !== 4'h5) begin errors++; $display("FAIL idle_addr: got %h exp 5", ram_addr); end
    rd_addr = 4'h9;
    checks++; if (ram_addr !== 4'h5) begin errors++; $display("FAIL idle_lag_before: got %h exp 5", ram_addr); end
    send(8'h22);
    checks++; if (ram_addr !== 4'h9) begin errors++; $display("FAIL idle_lag_after: got %h exp 9", ram_addr); end
    checks++; if (wr_cnt !== base || loading !== 1'b0) begin errors++; $display("FAIL idle_nowrite: writes %0d loading %b exp 0 0", wr_cnt - base, loading); end
  endtask

  task automatic test_frame_gaps;
    logic [DW-1:0] b;
    rd_addr = 4'hC;
    send(8'hA5);
    checks++; if (loading !== 1'b1 || ram_rw !== 1'b1) begin errors++; $display("FAIL gap_sync: loading %b rw %b exp 1 1", loading, ram_rw); end
    for (int i = 0; i < 4; i++) begin
      b = DW'(i + 1);
      send(b);
      checks++; if (ram_rw !== 1'b0 || ram_addr !== AW'(i) || ram_data !== b) begin errors++; $display("FAIL gap_write%0d: rw %b addr %h data %h exp 0 %h %h", i, ram_rw, ram_addr, ram_data, AW'(i), b); end
      checks++; if (frame_done !== (i == 3) || loading !== (i != 3)) begin errors++; $display("FAIL gap_flags%0d: done %b loading %b exp %b %b", i, frame_done, loading, i == 3, i != 3); end
      @(negedge clk);
      checks++; if (ram_rw !== 1'b1 || frame_done !== 1'b0) begin errors++; $display("FAIL gap_oneshot%0d: rw %b done %b exp 1 0", i, ram_rw, frame_done); end
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      repeat (2) @(negedge clk);
      b = DW'(i + 1);
      checks++; if (dout !== b) begin errors++; $display("FAIL readback%0d: got %h exp %h", i, dout, b); end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] seq [0:4];
    seq[0] = 8'hA5; seq[1] = 8'h31; seq[2] = 8'h32; seq[3] = 8'h33; seq[4] = 8'h34;
    rd_addr = 4'h7;
    @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin rx_data = seq[k]; rx_valid = 1'b1; end
      else rx_valid = 1'b0;
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        checks++; if (ram_rw !== 1'b0 || ram_addr !== AW'(k - 1) || ram_data !== seq[k]) begin errors++; $display("FAIL b2b_write%0d: rw %b addr %h data %h exp 0 %h %h", k - 1, ram_rw, ram_addr, ram_data, AW'(k - 1), seq[k]); end
        checks++; if (frame_done !== (k == 4)) begin errors++; $display("FAIL b2b_done%0d: got %b exp %b", k - 1, frame_done, k == 4); end
      end else if (k >= 5) begin
        checks++; if (ram_rw !== 1'b1 || ram_addr !== 4'h7 || loading !== 1'b0) begin errors++; $display("FAIL b2b_after%0d: rw %b addr %h loading %b exp 1 7 0", k, ram_rw, ram_addr, loading); end
      end
    end
  endtask

  task automatic test_timeout;
    int base;
    send(8'hA5);
    send(8'h10);
    checks++; if (ram_rw !== 1'b0 || ram_addr !== 4'h0 || ram_data !== 8'h10) begin errors++; $display("FAIL to_write: rw %b addr %h data %h exp 0 0 10", ram_rw, ram_addr, ram_data); end
    repeat (15) @(negedge clk);
    checks++; if (frame_err !== 1'b0 || loading !== 1'b1) begin errors++; $display("FAIL to_early: err %b loading %b exp 0 1", frame_err, loading); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b1 || loading !== 1'b0 || ram_rw !== 1'b1) begin errors++; $display("FAIL to_expire: err %b loading %b rw %b exp 1 0 1", frame_err, loading, ram_rw); end
    @(negedge clk);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL to_pulse: err %b exp 0", frame_err); end
    base = wr_cnt;
    send(8'h55);
    @(negedge clk);
    checks++; if (wr_cnt !== base || loading !== 1'b0) begin errors++; $display("FAIL to_idle: writes %0d loading %b exp 0 0", wr_cnt - base, loading); end
  endtask

  task automatic test_timeout_cancel;
    send(8'hA5);
    send(8'h61);
    repeat (14) @(negedge clk);
    send(8'h62);
    checks++; if (ram_rw !== 1'b0 || ram_addr !== 4'h1 || ram_data !== 8'h62) begin errors++; $display("FAIL cancel_write: rw %b addr %h data %h exp 0 1 62", ram_rw, ram_addr, ram_data); end
    checks++; if (frame_err !== 1'b0 || loading !== 1'b1) begin errors++; $display("FAIL cancel_state: err %b loading %b exp 0 1", frame_err, loading); end
    send(8'h63);
    send(8'h64);
    checks++; if (frame_done !== 1'b1 || ram_addr !== 4'h3) begin errors++; $display("FAIL cancel_done: done %b addr %h exp 1 3", frame_done, ram_addr); end
  endtask

  task automatic test_sync_as_data;
    send(8'hA5);
    send(8'hA5);
    checks++; if (ram_rw !== 1'b0 || ram_addr !== 4'h0 || ram_data !== 8'hA5 || loading !== 1'b1) begin errors++; $display("FAIL sync_data: rw %b addr %h data %h loading %b exp 0 0 a5 1", ram_rw, ram_addr, ram_data, loading); end
    send(8'hB0);
    send(8'hC0);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL sync_early_done: got %b exp 0", frame_done); end
    send(8'hD0);
    checks++; if (frame_done !== 1'b1 || ram_addr !== 4'h3 || ram_data !== 8'hD0) begin errors++; $display("FAIL sync_done: done %b addr %h data %h exp 1 3 d0", frame_done, ram_addr, ram_data); end
    @(negedge clk);
    checks++; if (mem[0] !== 8'hA5 || mem[3] !== 8'hD0) begin errors++; $display("FAIL sync_mem: m0 %h m3 %h exp a5 d0", mem[0], mem[3]); end
  endtask

  task automatic test_async_reset;
    int base;
    send(8'hA5);
    send(8'h01);
    checks++; if (ram_rw !== 1'b0) begin errors++; $display("FAIL ar_prewrite: rw %b exp 0", ram_rw); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ram_rw !== 1'b1 || ram_addr !== 4'h0 || ram_data !== 8'h00) begin errors++; $display("FAIL ar_outputs: rw %b addr %h data %h exp 1 0 00", ram_rw, ram_addr, ram_data); end
    checks++; if ({loading, frame_done, frame_err} !== 3'b000) begin errors++; $display("FAIL ar_flags: got %b exp 000", {loading, frame_done, frame_err}); end
    #1 rst = 1'b0;
    base = wr_cnt;
    send(8'h02);
    @(negedge clk);
    checks++; if (wr_cnt !== base || loading !== 1'b0) begin errors++; $display("FAIL ar_nowrite: writes %0d loading %b exp 0 0", wr_cnt - base, loading); end
    send(8'hA5);
    send(8'h02);
    checks++; if (ram_rw !== 1'b0 || ram_addr !== 4'h0 || ram_data !== 8'h02) begin errors++; $display("FAIL ar_resume: rw %b addr %h data %h exp 0 0 02", ram_rw, ram_addr, ram_data); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_frame_gaps();
    test_back_to_back();
    test_timeout();
    test_timeout_cancel();
    test_sync_as_data();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
